// File: rtl/pong_engine.sv
// pong_engine: match FSM, ball kinematics, wall and paddle collisions,
// scoring and win detection for a two-paddle court.
// Optional feature macro: PONG_SPEEDUP_EN. When defined, a rally counter
// raises the horizontal step every 4th paddle hit, up to MAX_STEP.
module pong_engine #(
  parameter int XW        = 11,
  parameter int SW        = 5,
  parameter int SCR_W     = 640,
  parameter int SCR_H     = 480,
  parameter int BORDER    = 30,
  parameter int PAD_X     = 45,
  parameter int SPEED_DIV = 100000,
  parameter int MAX_STEP  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          serve,
  input  logic          auto_serve,
  input  logic [SW-1:0] win_score,
  input  logic [5:0]    bat_half,
  input  logic [XW-1:0] p1_y,
  input  logic [XW-1:0] p2_y,
  output logic [XW-1:0] ball_x,
  output logic [XW-1:0] ball_y,
  output logic [SW-1:0] p1_score,
  output logic [SW-1:0] p2_score,
  output logic [1:0]    state,
  output logic          p1_win,
  output logic          p2_win,
  output logic          point
);

  localparam int CW  = (SPEED_DIV > 2) ? $clog2(SPEED_DIV) : 1;
  localparam int VW  = $clog2(MAX_STEP + 1);
  localparam int VYW = VW + 1;
  localparam int SX  = XW + 2;  // signed working width, headroom for under/overflow

  localparam logic signed [SX-1:0] L_F1   = SX'(PAD_X);
  localparam logic signed [SX-1:0] L_F2   = SX'(SCR_W - 1 - PAD_X);
  localparam logic signed [SX-1:0] L_YTOP = SX'(BORDER);
  localparam logic signed [SX-1:0] L_YBOT = SX'(SCR_H - 1 - BORDER);
  localparam logic signed [SX-1:0] L_XMAX = SX'(SCR_W - 1);

  localparam logic [XW-1:0] CX    = XW'(SCR_W / 2);
  localparam logic [XW-1:0] CY    = XW'(SCR_H / 2);
  localparam logic [XW-1:0] X_F1P = XW'(PAD_X + 1);
  localparam logic [XW-1:0] X_F2M = XW'(SCR_W - 2 - PAD_X);
  localparam logic [XW-1:0] Y_TOP = XW'(BORDER);
  localparam logic [XW-1:0] Y_BOT = XW'(SCR_H - 1 - BORDER);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SERVE = 2'b01,
    S_PLAY  = 2'b10,
    S_END   = 2'b11
  } state_t;

  state_t r_state, w_nstate;

  logic [CW-1:0]         r_cnt;
  logic [XW-1:0]         r_ball_x, r_ball_y;
  logic [VW-1:0]         r_vx_mag;
  logic signed [VYW-1:0] r_vy;
  logic                  r_xdir;
  logic                  r_srv_dir;   // serve direction: toward last conceder
  logic [SW-1:0]         r_p1_score, r_p2_score;
  logic                  r_p1_win, r_p2_win, r_point;
`ifdef PONG_SPEEDUP_EN
  logic [1:0]            r_rally;
`endif

  logic                  w_tick;
  logic signed [SX-1:0]  w_bx, w_by, w_vx, w_vy, w_nx, w_ny;
  logic [XW-1:0]         w_pad;
  logic signed [SX-1:0]  w_off, w_aoff, w_bh, w_bh2, w_bh4;
  logic                  w_in_zone, w_hit_r, w_hit_l, w_hit, w_miss, w_win;
  logic signed [VYW-1:0] w_vmag, w_vy_hit;
  logic [XW-1:0]         w_ny_c;
  logic                  w_wall;

  assign w_tick = (r_cnt == CW'(SPEED_DIV - 1));

  // Free-running movement tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

  // Candidate next position and collision geometry
  assign w_bx   = $signed({2'b00, r_ball_x});
  assign w_by   = $signed({2'b00, r_ball_y});
  assign w_vx   = $signed({{(SX-VW){1'b0}}, r_vx_mag});
  assign w_vy   = $signed({{(SX-VYW){r_vy[VYW-1]}}, r_vy});
  assign w_nx   = r_xdir ? (w_bx + w_vx) : (w_bx - w_vx);
  assign w_ny   = w_by + w_vy;
  assign w_pad  = r_xdir ? p2_y : p1_y;
  assign w_off  = w_by - $signed({2'b00, w_pad});
  assign w_aoff = w_off[SX-1] ? -w_off : w_off;
  assign w_bh   = $signed({{(SX-6){1'b0}}, bat_half});
  assign w_bh2  = $signed({{(SX-5){1'b0}}, bat_half[5:1]});
  assign w_bh4  = $signed({{(SX-4){1'b0}}, bat_half[5:2]});

  assign w_in_zone = (w_aoff <= w_bh);
  assign w_hit_r   = r_xdir  && (w_bx < L_F2) && (w_nx >= L_F2) && w_in_zone;
  assign w_hit_l   = !r_xdir && (w_bx > L_F1) && (w_nx <= L_F1) && w_in_zone;
  assign w_hit     = w_hit_r || w_hit_l;
  assign w_miss    = !w_hit && ((!r_xdir && (w_bx < w_vx)) || (r_xdir && (w_nx > L_XMAX)));
  assign w_win     = (r_p1_score >= win_score) || (r_p2_score >= win_score);

  // Bounce angle from the paddle zone that was struck
  always_comb begin
    w_vmag = VYW'(2);
    if (w_aoff <= w_bh4)      w_vmag = VYW'(0);
    else if (w_aoff <= w_bh2) w_vmag = VYW'(1);
    w_vy_hit = w_off[SX-1] ? -w_vmag : w_vmag;
  end

  // Top/bottom wall clamp
  always_comb begin
    w_wall = 1'b0;
    w_ny_c = w_ny[XW-1:0];
    if (w_ny < L_YTOP) begin
      w_wall = 1'b1;
      w_ny_c = Y_TOP;
    end else if (w_ny > L_YBOT) begin
      w_wall = 1'b1;
      w_ny_c = Y_BOT;
    end
  end

  // Match state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  // Match next-state; win check outranks serving
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nstate = S_SERVE;
      S_SERVE: begin
        if (w_win)                    w_nstate = S_END;
        else if (auto_serve || serve) w_nstate = S_PLAY;
      end
      S_PLAY:  if (w_tick && w_miss) w_nstate = S_SERVE;
      S_END:   if (serve) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Ball, velocity, score and flag datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ball_x   <= CX;
      r_ball_y   <= CY;
      r_vx_mag   <= VW'(1);
      r_vy       <= '0;
      r_xdir     <= 1'b1;
      r_srv_dir  <= 1'b1;
      r_p1_score <= '0;
      r_p2_score <= '0;
      r_p1_win   <= 1'b0;
      r_p2_win   <= 1'b0;
      r_point    <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      r_rally    <= '0;
`endif
    end else begin
      r_point <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ball_x   <= CX;
          r_ball_y   <= CY;
          r_vx_mag   <= VW'(1);
          r_vy       <= '0;
          r_xdir     <= 1'b1;
          r_srv_dir  <= 1'b1;
          r_p1_score <= '0;
          r_p2_score <= '0;
          r_p1_win   <= 1'b0;
          r_p2_win   <= 1'b0;
        end
        S_SERVE: begin
          r_ball_x <= CX;
          r_ball_y <= CY;
          r_vx_mag <= VW'(1);
          r_vy     <= '0;
          r_xdir   <= r_srv_dir;
`ifdef PONG_SPEEDUP_EN
          r_rally  <= '0;
`endif
          if (w_win) begin
            r_p1_win <= (r_p1_score > r_p2_score);
            r_p2_win <= !(r_p1_score > r_p2_score);
          end
        end
        S_PLAY: begin
          if (w_tick) begin
            if (w_miss) begin
              r_point <= 1'b1;
              if (r_xdir) begin
                r_srv_dir <= 1'b1;
                if (r_p1_score != {SW{1'b1}}) r_p1_score <= r_p1_score + SW'(1);
              end else begin
                r_srv_dir <= 1'b0;
                if (r_p2_score != {SW{1'b1}}) r_p2_score <= r_p2_score + SW'(1);
              end
            end else begin
              r_ball_y <= w_ny_c;
              if (w_hit) begin
                // paddle sets the new angle; wall clamp still fixes y
                r_ball_x <= w_hit_r ? X_F2M : X_F1P;
                r_xdir   <= !r_xdir;
                r_vy     <= w_vy_hit;
`ifdef PONG_SPEEDUP_EN
                r_rally  <= r_rally + 2'd1;
                if (r_rally == 2'd3 && r_vx_mag < VW'(MAX_STEP))
                  r_vx_mag <= r_vx_mag + VW'(1);
`endif
              end else begin
                r_ball_x <= w_nx[XW-1:0];
                if (w_wall) r_vy <= -r_vy;
              end
            end
          end
        end
        S_END: begin
          if (serve) begin
            r_p1_score <= '0;
            r_p2_score <= '0;
            r_p1_win   <= 1'b0;
            r_p2_win   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ball_x   = r_ball_x;
  assign ball_y   = r_ball_y;
  assign p1_score = r_p1_score;
  assign p2_score = r_p2_score;
  assign state    = r_state;
  assign p1_win   = r_p1_win;
  assign p2_win   = r_p2_win;
  assign point    = r_point;

endmodule
